// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8-bit serial transmitter, LSB first,
// optional parity, 1 or 2 stop bits, queued frames sent back-to-back.
module uart_tx_fifo #(
  parameter int ClkFrequency = 10000000,
  parameter int Baud         = 115200,
  parameter int FifoDepth    = 16,
  parameter int ParityEn     = 0,
  parameter int ParityOdd    = 0,
  parameter int StopBits     = 1,
  localparam int AW          = $clog2(FifoDepth)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          TxD,
  output logic          TxD_busy,
  output logic          tx_done
);

  localparam int Div = (ClkFrequency + Baud / 2) / Baud;
  localparam int CW  = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(Div - 1);
  localparam logic PAR_EN  = (ParityEn != 0);
  localparam logic PAR_ODD = (ParityOdd != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (Div < 2) begin : g_div_chk
    $error("uart_tx_fifo: clocks per bit must be at least 2");
  end
  if (StopBits != 1 && StopBits != 2) begin : g_stop_chk
    $error("uart_tx_fifo: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_fifo: FifoDepth must be a power of 2, >= 2");
  end

  logic [7:0]    r_mem [FifoDepth];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          r_ovf;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          r_stop;
  logic [7:0]    r_sh;
  logic          r_par;
  logic          r_txd;
  logic          r_done;

  logic [AW:0]   w_level;
  logic [7:0]    w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_bnd;
  logic          w_last;

  assign w_level  = r_wp - r_rp;
  assign level    = w_level;
  assign full     = (w_level == (AW+1)'(FifoDepth));
  assign empty    = (r_wp == r_rp);
  assign overflow = r_ovf;
  assign w_head   = r_mem[r_rp[AW-1:0]];

  // full is taken before any pop, so a write while full is lost
  assign w_push = wr_en & ~full;
  assign w_bnd  = (r_cnt == DIV_M1);
  assign w_last = (r_stop == 1'(StopBits - 1));
  assign w_pop  = ~empty & ((r_state == S_IDLE) |
                  ((r_state == S_STOP) & w_bnd & w_last));

  assign TxD      = r_txd;
  assign TxD_busy = (r_state != S_IDLE);
  assign tx_done  = r_done;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (wr_en && full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_stop  <= 1'b0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) r_cnt <= w_bnd ? '0 : r_cnt + 1'b1;
      unique case (r_state)
        S_IDLE: ;
        S_START: if (w_bnd) begin
          r_txd   <= r_sh[0];
          r_idx   <= '0;
          r_state <= S_DATA;
        end
        S_DATA: if (w_bnd) begin
          r_sh  <= r_sh >> 1;
          r_idx <= r_idx + 1'b1;
          if (r_idx == 3'd7) begin
            r_stop <= 1'b0;
            if (PAR_EN) begin
              r_txd   <= r_par;
              r_state <= S_PARITY;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end
          end else begin
            r_txd <= r_sh[1];
          end
        end
        S_PARITY: if (w_bnd) begin
          r_txd   <= 1'b1;
          r_stop  <= 1'b0;
          r_state <= S_STOP;
        end
        S_STOP: if (w_bnd) begin
          if (w_last) begin
            r_done <= 1'b1;
            if (!w_pop) r_state <= S_IDLE;
          end else begin
            r_stop <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // a pop starts the next frame, from IDLE or straight out of STOP
      if (w_pop) begin
        r_sh    <= w_head;
        r_par   <= (^w_head) ^ PAR_ODD;
        r_txd   <= 1'b0;
        r_cnt   <= '0;
        r_state <= S_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at 16 clocks per bit,
// 8N1 plus even/odd parity with two stop bits.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       wa;
  logic [7:0] da;
  logic       fa, ea, oa, ta, ba, xa;
  logic [4:0] la;

  logic       wpq;
  logic [7:0] dpq;
  logic       fp, ep, op, tp, bp, xp;
  logic [4:0] lp;
  logic       fq, eq, oq, tq, bq, xq;
  logic [4:0] lq;

  uart_tx_fifo #(
    .ClkFrequency(1600000), .Baud(100000), .FifoDepth(16),
    .ParityEn(0), .ParityOdd(0), .StopBits(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wa), .wr_data(da),
    .full(fa), .empty(ea), .level(la), .overflow(oa),
    .TxD(ta), .TxD_busy(ba), .tx_done(xa)
  );

  uart_tx_fifo #(
    .ClkFrequency(1600000), .Baud(100000), .FifoDepth(16),
    .ParityEn(1), .ParityOdd(0), .StopBits(2)
  ) u_even (
    .clk(clk), .rst_n(rst_n), .wr_en(wpq), .wr_data(dpq),
    .full(fp), .empty(ep), .level(lp), .overflow(op),
    .TxD(tp), .TxD_busy(bp), .tx_done(xp)
  );

  uart_tx_fifo #(
    .ClkFrequency(1600000), .Baud(100000), .FifoDepth(16),
    .ParityEn(1), .ParityOdd(1), .StopBits(2)
  ) u_odd (
    .clk(clk), .rst_n(rst_n), .wr_en(wpq), .wr_data(dpq),
    .full(fq), .empty(eq), .level(lq), .overflow(oq),
    .TxD(tq), .TxD_busy(bq), .tx_done(xq)
  );

  int n_chk = 0;
  int n_err = 0;
  int busy_cnt;
  int ferr;
  int bad;
  int dn[$];
  logic [7:0] rx [17];
  logic [9:0] bits;
  logic [11:0] bits_e;
  logic [11:0] bits_o;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // samples u_dut at negedges c0..c1 after the first write edge
  task automatic mon(input int c0, input int c1, input int nfr);
    for (int c = c0; c <= c1; c++) begin
      int k, f, b;
      @(negedge clk);
      if (ba) busy_cnt++;
      if (xa) dn.push_back(c);
      k = (c - 1) % 160;
      f = (c - 1) / 160;
      b = k / 16;
      if (f < nfr && (k % 16) == 8) begin
        if (b == 0 && ta !== 1'b0) ferr++;
        else if (b == 9 && ta !== 1'b1) ferr++;
        else if (b >= 1 && b <= 8) rx[f][b-1] = ta;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wa = 1'b0; da = '0; wpq = 1'b0; dpq = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd", ta, 1);
    chk("rst_busy", ba, 0);
    chk("rst_done", xa, 0);
    chk("rst_ovf", oa, 0);
    chk("rst_full", fa, 0);
    chk("rst_empty", ea, 1);
    chk("rst_level", la, 0);
    chk("rst_txd_par", tp, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single 8N1 frame of 0x55
    wa = 1'b1; da = 8'h55;
    @(negedge clk); wa = 1'b0;
    chk("t1_level1", la, 1);
    chk("t1_txd_idle", ta, 1);
    @(negedge clk);
    chk("t1_txd_low", ta, 0);
    chk("t1_busy", ba, 1);
    chk("t1_level0", la, 0);
    bits = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? 8 : 16) @(negedge clk);
      chk($sformatf("t1_bit%0d", b), ta, bits[b]);
    end
    repeat (7) @(negedge clk);
    chk("t1_done_early", xa, 0);
    chk("t1_busy_late", ba, 1);
    @(negedge clk);
    chk("t1_done", xa, 1);
    chk("t1_busy_off", ba, 0);
    @(negedge clk);
    chk("t1_done_pulse", xa, 0);

    // 0x07 with parity and two stop bits
    wpq = 1'b1; dpq = 8'h07;
    @(negedge clk); wpq = 1'b0; dpq = 8'hFF;
    @(negedge clk);
    chk("t2_start_e", tp, 0);
    bits_e = {2'b11, 1'b1, 8'h07, 1'b0};
    bits_o = {2'b11, 1'b0, 8'h07, 1'b0};
    for (int b = 0; b < 12; b++) begin
      repeat ((b == 0) ? 8 : 16) @(negedge clk);
      chk($sformatf("t2e_bit%0d", b), tp, bits_e[b]);
      chk($sformatf("t2o_bit%0d", b), tq, bits_o[b]);
    end
    repeat (7) @(negedge clk);
    chk("t2_done_early", xp, 0);
    chk("t2_busy_late", bq, 1);
    @(negedge clk);
    chk("t2_done_e", xp, 1);
    chk("t2_done_o", xq, 1);
    chk("t2_busy_off", bp, 0);

    // three back-to-back frames
    busy_cnt = 0; ferr = 0; dn.delete();
    for (int i = 0; i < 17; i++) rx[i] = '0;
    @(negedge clk);
    wa = 1'b1; da = 8'h41;
    @(negedge clk); da = 8'h42;
    @(negedge clk); if (ba) busy_cnt++; da = 8'h43;
    @(negedge clk); if (ba) busy_cnt++; wa = 1'b0; da = 8'h00;
    chk("t3_level", la, 2);
    mon(3, 490, 3);
    chk("t3_busy_cycles", busy_cnt, 480);
    chk("t3_done_cnt", dn.size(), 3);
    chk("t3_done0", dn[0], 161);
    chk("t3_done1", dn[1], 321);
    chk("t3_done2", dn[2], 481);
    chk("t3_framing", ferr, 0);
    chk("t3_rx0", rx[0], 8'h41);
    chk("t3_rx1", rx[1], 8'h42);
    chk("t3_rx2", rx[2], 8'h43);

    // 18 consecutive writes into a 16-deep FIFO
    busy_cnt = 0; ferr = 0; dn.delete();
    for (int i = 0; i < 17; i++) rx[i] = '0;
    @(negedge clk);
    wa = 1'b1; da = pat(0);
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      if (c == 15) begin
        chk("t4_full15", fa, 0);
        chk("t4_level15", la, 15);
      end
      if (c == 16) begin
        chk("t4_full16", fa, 1);
        chk("t4_level16", la, 16);
        chk("t4_ovf16", oa, 0);
      end
      if (c == 17) begin
        chk("t4_ovf17", oa, 1);
        chk("t4_level17", la, 16);
      end
      if (c < 17) da = pat(c + 1);
      else wa = 1'b0;
    end
    mon(18, 2730, 17);
    chk("t4_done_cnt", dn.size(), 17);
    chk("t4_done_last", dn[16], 2721);
    chk("t4_framing", ferr, 0);
    chk("t4_idle", ba, 0);
    chk("t4_empty", ea, 1);
    chk("t4_ovf_sticky", oa, 1);
    for (int i = 0; i < 17; i++)
      chk($sformatf("t4_rx%0d", i), rx[i], pat(i));

    // reset during data bit 4 with 5 bytes queued
    @(negedge clk);
    wa = 1'b1; da = 8'h00;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) wa = 1'b0;
    end
    chk("t5_level", la, 5);
    repeat (84) @(negedge clk);
    chk("t5_midbit", ta, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_txd_async", ta, 1);
    chk("t5_level0", la, 0);
    chk("t5_empty", ea, 1);
    chk("t5_ovf", oa, 0);
    chk("t5_busy", ba, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ta !== 1'b1 || ba !== 1'b0) bad++;
    end
    chk("t5_stays_idle", bad, 0);

    // write while full at the stop-bit pop edge
    wa = 1'b1; da = pat(3);
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (c == 16) wa = 1'b0;
      else da = pat(c + 4);
    end
    chk("t6_full", fa, 1);
    chk("t6_level16", la, 16);
    chk("t6_ovf0", oa, 0);
    repeat (144) @(negedge clk);
    chk("t6_pre_done", xa, 0);
    wa = 1'b1; da = 8'hEE;
    @(negedge clk); wa = 1'b0;
    chk("t6_done", xa, 1);
    chk("t6_level15", la, 15);
    chk("t6_not_full", fa, 0);
    chk("t6_ovf1", oa, 1);
    chk("t6_next_start", ta, 0);
    chk("t6_busy", ba, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
